// File: rtl/mem_slave_pkg.sv
// Shared bus constants, FSM state encoding and SRAM lane enables for mem_slave.
package mem_slave_pkg;

    localparam int ADR_W   = 20;
    localparam int DAT_W   = 16;
    localparam int SRAM_AW = 19;
    localparam int IO_AW   = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_MEM_LO  = 3'd1;
    localparam logic [2:0] ST_MEM_HI  = 3'd2;
    localparam logic [2:0] ST_IO_WAIT = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

    function automatic logic is_mem(input logic [2:0] s);
        return (s == ST_MEM_LO) || (s == ST_MEM_HI);
    endfunction

endpackage

// File: rtl/mem_slave_lane.sv
// Byte-lane steering for SRAM writes and read-byte assembly for mem_slave.
module mem_slave_lane
    import mem_slave_pkg::*;
(
    input  logic [DAT_W-1:0] dat,
    input  logic             byte_acc,
    input  logic             odd,
    input  logic             hi_phase,
    input  logic [DAT_W-1:0] rdat,
    input  logic [7:0]       lo_byte,
    output logic [1:0]       be,
    output logic [DAT_W-1:0] wdat,
    output logic [DAT_W-1:0] rd
);

    always_comb begin
        be   = BE_WORD;
        wdat = dat;
        rd   = rdat;
        if (byte_acc) begin
            be   = odd ? BE_HI : BE_LO;
            wdat = {dat[7:0], dat[7:0]};
            rd   = {8'h00, odd ? rdat[15:8] : rdat[7:0]};
        end else if (odd && !hi_phase) begin
            // unaligned word, first half: high lane carries the low result byte
            be   = BE_HI;
            wdat = {dat[7:0], dat[7:0]};
            rd   = {8'h00, rdat[15:8]};
        end else if (odd) begin
            be   = BE_LO;
            wdat = {dat[15:8], dat[15:8]};
            rd   = {rdat[7:0], lo_byte};
        end
    end

endmodule

// File: rtl/mem_slave.sv
// Bus slave bridging to wait-stated SRAM and a handshaked I/O port.
// Optional I/O watchdog enabled by defining MEM_SLAVE_IO_TIMEOUT_EN.
module mem_slave
    import mem_slave_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int IO_TIMEOUT  = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [ADR_W-1:0]   adr_i,
    input  logic [DAT_W-1:0]   dat_i,
    output logic [DAT_W-1:0]   dat_o,
    input  logic               we_i,
    input  logic               mio_i,
    input  logic               byte_i,
    input  logic               stb_i,
    output logic               ack_o,
    output logic [SRAM_AW-1:0] sram_adr,
    output logic [DAT_W-1:0]   sram_wdat,
    input  logic [DAT_W-1:0]   sram_rdat,
    output logic [1:0]         sram_be,
    output logic               sram_we,
    output logic               sram_en,
    output logic [IO_AW-1:0]   io_adr,
    output logic [DAT_W-1:0]   io_dat_o,
    input  logic [DAT_W-1:0]   io_dat_i,
    output logic               io_we,
    output logic               io_byte,
    output logic               io_stb,
    input  logic               io_ack
);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
        $error("mem_slave: WAIT_STATES out of range");
    end
    if (IO_TIMEOUT < 1 || IO_TIMEOUT > 65535) begin : g_bad_tmo
        $error("mem_slave: IO_TIMEOUT out of range");
    end

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic [2:0]       state, state_n;
    logic [ADR_W-1:0] adr_q;
    logic [DAT_W-1:0] dat_q;
    logic             we_q, byte_q;
    logic [3:0]       wcnt;
    logic [7:0]       lo_q;
    logic             last, odd_word, tmo, a_we;
    logic [DAT_W-1:0] rd;

    assign last     = (wcnt == WS);
    assign odd_word = adr_q[0] && !byte_q;
    assign a_we     = (state == ST_IDLE) ? we_i : we_q;

`ifdef MEM_SLAVE_IO_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(IO_TIMEOUT - 1);
    logic [15:0] tcnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || state != ST_IO_WAIT) tcnt <= '0;
        else                             tcnt <= tcnt + 16'd1;
    end

    assign tmo = (state == ST_IO_WAIT) && (tcnt == TMO_LAST);
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:    if (stb_i) state_n = mio_i ? ST_MEM_LO : ST_IO_WAIT;
            ST_MEM_LO:  if (last) state_n = odd_word ? ST_MEM_HI : ST_DONE;
            ST_MEM_HI:  if (last) state_n = ST_DONE;
            ST_IO_WAIT: if (io_ack || tmo) state_n = ST_DONE;
            default:    state_n = ST_IDLE;
        endcase
    end

    mem_slave_lane u_lane (
        .dat      (dat_q),
        .byte_acc (byte_q),
        .odd      (adr_q[0]),
        .hi_phase (state == ST_MEM_HI),
        .rdat     (sram_rdat),
        .lo_byte  (lo_q),
        .be       (sram_be),
        .wdat     (sram_wdat),
        .rd       (rd)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            sram_en <= 1'b0;
            sram_we <= 1'b0;
            io_stb  <= 1'b0;
            dat_o   <= '0;
            wcnt    <= '0;
        end else begin
            state   <= state_n;
            sram_en <= is_mem(state_n);
            sram_we <= is_mem(state_n) && a_we;
            io_stb  <= (state_n == ST_IO_WAIT);
            if (state_n != state)  wcnt <= '0;
            else if (is_mem(state)) wcnt <= wcnt + 4'd1;
            if (last && !we_q && ((state == ST_MEM_LO && !odd_word) ||
                                  state == ST_MEM_HI))
                dat_o <= rd;
            if (state == ST_IO_WAIT) begin
                if (io_ack) begin
                    if (!we_q) dat_o <= io_dat_i;
                end else if (tmo) begin
                    dat_o <= 16'hFFFF;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && state == ST_IDLE && stb_i) begin
            adr_q  <= adr_i;
            dat_q  <= dat_i;
            we_q   <= we_i;
            byte_q <= byte_i;
        end
        if (state == ST_MEM_LO && last && odd_word) lo_q <= rd[7:0];
    end

    assign ack_o    = (state == ST_DONE);
    assign sram_adr = (state == ST_MEM_HI) ? adr_q[ADR_W-1:1] + 19'd1
                                           : adr_q[ADR_W-1:1];
    assign io_adr   = adr_q[IO_AW-1:0];
    assign io_dat_o = dat_q;
    assign io_we    = we_q;
    assign io_byte  = byte_q;

endmodule
